adc_capture_sequencer: RTL and testbench

//  Sequences ADC capture into fixed-length packets for the modem receive path.
//  On start: enables the ADC, waits a settle window, then frames PKT_NUM packets of PKT_LEN samples.

---
 rtl/adc_capture_sequencer.sv | 121 ++++++++++++
 tb/tb_adc_capture_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// Sequences ADC capture into PKT_NUM packets of PKT_LEN samples after a settle window.
// Latency: one cycle from an accepted ADC sample to the m_data_o beat.
// Backpressure: single-entry output register; a sample arriving while it is stalled is dropped and ovf_o set.
module adc_capture_sequencer #(
  parameter int ADC_WIDTH     = 14,
  parameter int PKT_LEN       = 500,
  parameter int PKT_NUM       = 10,
  parameter int SETTLE_CYCLES = 50,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADC_WIDTH-1:0] adc_data_i,
  input  logic                 adc_valid_i,
  output logic                 adc_en_o,
  output logic [ADC_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic [((PKT_NUM > 1) ? $clog2(PKT_NUM) : 1)-1:0] pkt_idx_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o
);

  localparam int IDX_W    = (PKT_NUM > 1) ? $clog2(PKT_NUM) : 1;
  localparam int CNT_W    = $clog2(PKT_LEN + 1);
  localparam int WAIT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_GAP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  samp_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load, drop, last_load, settle_end, gap_end, pkt_last, run_start, aborting;

  assign load       = (state == S_CAPTURE) && adc_valid_i && (!m_valid_o || m_ready_i);
  assign drop       = (state == S_CAPTURE) && adc_valid_i && m_valid_o && !m_ready_i;
  assign last_load  = load && (samp_cnt == CNT_W'(PKT_LEN - 1));
  assign settle_end = (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1));
  assign gap_end    = (wait_cnt == WAIT_W'(GAP_CYCLES - 1));
  assign pkt_last   = (pkt_idx_o == IDX_W'(PKT_NUM - 1));
  assign run_start  = (state == S_IDLE) && start_i && !abort_i;
  assign aborting   = (state != S_IDLE) && abort_i;
  assign busy_o     = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    adc_en_o  = 1'b0;
    done_o    = 1'b0;
    case (state)
      S_IDLE:    if (run_start) state_nxt = S_ARM;
      S_ARM: begin
        adc_en_o = 1'b1;
        if (settle_end) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        adc_en_o = 1'b1;
        if (last_load) state_nxt = pkt_last ? S_DONE : S_GAP;
      end
      S_GAP: begin
        adc_en_o = 1'b1;
        if (gap_end) state_nxt = S_CAPTURE;
      end
      S_DONE: begin
        // Completion waits for the final beat to leave the output register.
        if (!m_valid_o) begin
          done_o    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default:   state_nxt = S_IDLE;
    endcase
    if (aborting) begin
      state_nxt = S_IDLE;
      done_o    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      samp_cnt  <= '0;
      wait_cnt  <= '0;
      pkt_idx_o <= '0;
      ovf_o     <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)                   wait_cnt <= '0;
      else if (state == S_ARM || state == S_GAP) wait_cnt <= wait_cnt + WAIT_W'(1);

      if (state_nxt != S_CAPTURE) samp_cnt <= '0;
      else if (load)              samp_cnt <= samp_cnt + CNT_W'(1);

      if (run_start)                                   pkt_idx_o <= '0;
      else if (state == S_GAP && gap_end && !aborting) pkt_idx_o <= pkt_idx_o + IDX_W'(1);

      if (run_start)              ovf_o <= 1'b0;
      else if (drop && !aborting) ovf_o <= 1'b1;

      if (aborting) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end else if (load) begin
        m_valid_o <= 1'b1;
        m_data_o  <= adc_data_i;
        m_last_o  <= last_load;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomised bench for adc_capture_sequencer: a transaction-level model on a small instance,
// plus a stream scoreboard on a default-parameter instance.
module tb_adc_capture_sequencer;

  localparam int W = 14, L = 8, N = 2, ST = 4, GP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start_i, abort_i, adc_valid_i, m_ready_i;
  logic [W-1:0] adc_data_i, m_data_o;
  logic         adc_en_o, m_valid_o, m_last_o, busy_o, done_o, ovf_o;
  logic [0:0]   pkt_idx_o;

  adc_capture_sequencer #(.ADC_WIDTH(W), .PKT_LEN(L), .PKT_NUM(N),
                          .SETTLE_CYCLES(ST), .GAP_CYCLES(GP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .adc_data_i(adc_data_i), .adc_valid_i(adc_valid_i), .adc_en_o(adc_en_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .pkt_idx_o(pkt_idx_o), .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o));

  logic         rst6, start6, abort6, av6, r6;
  logic [W-1:0] ad6, md6;
  logic         ae6, mv6, ml6, busy6, done6, ovf6;
  logic [3:0]   pidx6;

  adc_capture_sequencer dut6 (
    .clk(clk), .rst(rst6), .start_i(start6), .abort_i(abort6),
    .adc_data_i(ad6), .adc_valid_i(av6), .adc_en_o(ae6),
    .m_data_o(md6), .m_valid_o(mv6), .m_last_o(ml6), .m_ready_i(r6),
    .pkt_idx_o(pidx6), .busy_o(busy6), .done_o(done6), .ovf_o(ovf6));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 settling, 2 capturing, 3 gap, 4 draining
  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
  beat_t  hold[$];
  int     ph = 0, left = 0, got = 0, pkt = 0;
  bit     movf = 0;
  int     beats = 0, lasts = 0, dones = 0;
  logic [W-1:0] ramp = '0;

  task automatic model_next();
    bit had, stall;
    beat_t b;
    if (rst) begin
      ph = 0; left = 0; got = 0; pkt = 0; movf = 0; hold.delete();
      return;
    end
    had   = (hold.size() != 0);
    stall = had && !m_ready_i;
    if (had && m_ready_i) void'(hold.pop_front());
    if (ph == 0) begin
      if (start_i && !abort_i) begin ph = 1; left = ST; movf = 0; pkt = 0; end
    end else if (abort_i) begin
      ph = 0; got = 0; hold.delete();
    end else begin
      case (ph)
        1: begin left--; if (left == 0) begin ph = 2; got = 0; end end
        2: if (adc_valid_i) begin
             if (stall) movf = 1;
             else begin
               b.d = adc_data_i; b.l = (got == L - 1);
               hold.push_back(b);
               got++;
               if (got == L) begin
                 if (pkt < N - 1) begin ph = 3; left = GP; end
                 else ph = 4;
               end
             end
           end
        3: begin left--; if (left == 0) begin pkt++; got = 0; ph = 2; end end
        4: if (!had) ph = 0;
        default: ph = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("busy", busy_o, ph != 0);
    chk("adc_en", adc_en_o, ph >= 1 && ph <= 3);
    chk("done", done_o, ph == 4 && hold.size() == 0);
    chk("ovf", ovf_o, movf);
    chk("pkt_idx", pkt_idx_o, pkt);
    chk("m_valid", m_valid_o, hold.size() != 0);
    if (hold.size() != 0) begin
      chk("m_data", m_data_o, hold[0].d);
      chk("m_last", m_last_o, hold[0].l);
    end
  endtask

  task automatic step();
    if (m_valid_o && m_ready_i) begin beats++; if (m_last_o) lasts++; end
    if (done_o) dones++;
    model_next();
    @(posedge clk); #1;
    start_i = 1'b0; abort_i = 1'b0;
    ramp++; adc_data_i = ramp;
    compare_all();
  endtask

  task automatic drive(input int vp, input int rp, input int ap);
    adc_valid_i = ($urandom_range(99) < vp);
    m_ready_i   = ($urandom_range(99) < rp);
    abort_i     = (ap > 0) && ($urandom_range(999) < ap);
    start_i     = ($urandom_range(19) == 0);
  endtask

  task automatic begin_run();
    beats = 0; lasts = 0; dones = 0;
    start_i = 1'b1;
    step();
  endtask

  task automatic run(input int vp, input int rp, input int ap);
    int n = 0;
    begin_run();
    while (ph != 0 && n < 400) begin drive(vp, rp, ap); step(); n++; end
    chk("run_bound", n < 400, 1);
  endtask

  initial begin
    int n, tail, order_err, pos_err, beats6, lasts6, dones6;
    logic [W-1:0] prev6, ramp6;

    rst = 1'b1; start_i = 0; abort_i = 0; adc_valid_i = 0; m_ready_i = 1; adc_data_i = '0;
    rst6 = 1'b1; start6 = 0; abort6 = 0; av6 = 0; r6 = 0; ad6 = '0;
    step(); step();
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    rst = 1'b0;
    step();

    // 1: continuous ADC, always ready
    adc_valid_i = 1; m_ready_i = 1;
    begin_run();
    chk("t1_adc_en_rise", adc_en_o, 1);
    n = 0;
    while (ph != 0 && n < 200) begin step(); n++; end
    chk("t1_bound", n < 200, 1);
    step();
    chk("t1_beats", beats, 2 * L);
    chk("t1_lasts", lasts, N);
    chk("t1_dones", dones, 1);
    chk("t1_ovf", ovf_o, 0);

    // 2: three-cycle stall mid packet 0
    begin_run();
    n = 0;
    while (ph != 0 && n < 200) begin
      adc_valid_i = 1; m_ready_i = !(n >= 8 && n < 11);
      step(); n++;
    end
    chk("t2_bound", n < 200, 1);
    step();
    chk("t2_beats", beats, 2 * L);
    chk("t2_lasts", lasts, N);
    chk("t2_ovf_sticky", ovf_o, 1);

    // 3: sparse ADC
    begin_run();
    n = 0;
    while (ph != 0 && n < 300) begin
      adc_valid_i = (n % 3 == 0); m_ready_i = 1;
      step(); n++;
    end
    chk("t3_bound", n < 300, 1);
    step();
    chk("t3_beats", beats, 2 * L);
    chk("t3_lasts", lasts, N);

    // 4: abort on the 5th beat of packet 0
    adc_valid_i = 1; m_ready_i = 1;
    begin_run();
    n = 0;
    while (ph != 0 && n < 200) begin
      if (hold.size() != 0 && beats == 4) abort_i = 1'b1;
      step(); n++;
    end
    chk("t4_abort_busy", busy_o, 0);
    chk("t4_abort_valid", m_valid_o, 0);
    step(); step();
    chk("t4_beats", beats, 5);
    chk("t4_no_last", lasts, 0);
    chk("t4_no_done", dones, 0);
    adc_valid_i = 1; m_ready_i = 1;
    begin_run();
    chk("t4_ovf_cleared", ovf_o, 0);
    n = 0;
    while (ph != 0 && n < 200) begin step(); n++; end
    step();
    chk("t4_rerun_beats", beats, 2 * L);
    chk("t4_rerun_done", dones, 1);

    // 5: control corners
    start_i = 1; abort_i = 1;
    step();
    chk("t5_start_abort_idle", busy_o, 0);
    begin_run();
    n = 0;
    while (ph != 3 && n < 200) begin
      adc_valid_i = 1; m_ready_i = 1; start_i = (ph == 2);
      step(); n++;
    end
    chk("t5_reach_gap", ph, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_valid", m_valid_o, 0);
    chk("t5_rst_data", m_data_o, 0);
    chk("t5_rst_last", m_last_o, 0);
    chk("t5_rst_idx", pkt_idx_o, 0);
    chk("t5_rst_en", adc_en_o, 0);
    step();

    // random runs
    for (int r = 0; r < 8; r++) run(40 + $urandom_range(60), 40 + $urandom_range(60), (r % 3 == 2) ? 8 : 0);
    step();

    // 6: default parameters, 70% ready
    @(posedge clk); #1;
    rst6 = 1'b0;
    @(posedge clk); #1;
    ramp6 = '0; ad6 = ramp6; av6 = 1; start6 = 1;
    beats6 = 0; lasts6 = 0; dones6 = 0; order_err = 0; pos_err = 0; prev6 = '0;
    n = 0; tail = 0;
    while (n < 20000 && tail < 5) begin
      if (mv6 && r6) begin
        beats6++;
        if (beats6 > 1 && md6 <= prev6) order_err++;
        prev6 = md6;
        if (ml6) begin
          lasts6++;
          if (beats6 % 500 != 0 || pidx6 != 4'(lasts6 - 1)) pos_err++;
        end else if (beats6 % 500 == 0) pos_err++;
      end
      if (done6) dones6++;
      if (dones6 > 0) tail++;
      @(posedge clk); #1;
      start6 = 0;
      r6 = ($urandom_range(99) < 70);
      ramp6++; ad6 = ramp6;
      n++;
    end
    chk("t6_bound", n < 20000, 1);
    chk("t6_beats", beats6, 5000);
    chk("t6_lasts", lasts6, 10);
    chk("t6_dones", dones6, 1);
    chk("t6_order", order_err, 0);
    chk("t6_last_pos", pos_err, 0);
    chk("t6_idle", busy6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
